mem_arbiter_mo: RTL and testbench

MEM_ARBITER_MO -- requirements
Module: mem_arbiter_mo

---
 rtl/mem_arbiter_mo_if.sv | 41 ++++
 rtl/mem_arbiter_mo.sv | 112 +++++++++++
 tb/tb_mem_arbiter_mo.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_mo_if.sv
// Bundle of requester-side and memory-side signals for mem_arbiter_mo.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_mo_if #(
  parameter int N       = 3,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int MAX_OUT = 4
);
  logic [N-1:0]                  req_valid;
  logic [N-1:0]                  req_ready;
  logic [N-1:0]                  req_we;
  logic [N*ADDR_W-1:0]           req_addr;
  logic [N*DATA_W-1:0]           req_wdata;
  logic [N-1:0]                  resp_valid;
  logic [DATA_W-1:0]             resp_data;
  logic                          mem_req_valid;
  logic                          mem_req_ready;
  logic                          mem_req_we;
  logic [ADDR_W-1:0]             mem_req_addr;
  logic [DATA_W-1:0]             mem_req_wdata;
  logic                          mem_resp_valid;
  logic [DATA_W-1:0]             mem_resp_data;
  logic [$clog2(MAX_OUT+1)-1:0]  outstanding;
  logic                          spurious_err;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output req_ready, resp_valid, resp_data,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output outstanding, spurious_err
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  req_ready, resp_valid, resp_data,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  outstanding, spurious_err
  );
endinterface

// File: rtl/mem_arbiter_mo.sv
// N-port memory arbiter with multiple outstanding in-order responses.
// An owner FIFO records the granted port of each accepted request for response routing.
module mem_arbiter_mo #(
  parameter int N         = 3,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_OUT   = 4,
  parameter int PRIO_MODE = 0
) (
  input  logic             clk,
  input  logic             resetN,
  mem_arbiter_mo_if.slave  bus
);
  localparam int          IDX_W = $clog2(N);
  localparam int          PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int          CNT_W = $clog2(MAX_OUT + 1);
  localparam int unsigned NU    = N;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0] owner_q [MAX_OUT];
  logic [IDX_W-1:0] owner_d [MAX_OUT];
  logic             spurious_q, spurious_d;

  logic             found;
  logic [IDX_W-1:0] winner;
  logic             not_full;
  logic             accept;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    found  = 1'b0;
    winner = '0;
    if (PRIO_MODE == 1) begin
      for (int unsigned i = 0; i < NU; i++) begin
        if (!found && bus.req_valid[i]) begin
          found  = 1'b1;
          winner = IDX_W'(i);
        end
      end
    end else begin
      for (int unsigned k = 0; k < NU; k++) begin
        if (!found && bus.req_valid[(32'(rr_ptr_q) + k) % NU]) begin
          found  = 1'b1;
          winner = IDX_W'((32'(rr_ptr_q) + k) % NU);
        end
      end
    end
  end

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign not_full = (count_q < CNT_W'(MAX_OUT));
  assign accept   = bus.mem_req_valid && bus.mem_req_ready;
  assign pop      = resetN && bus.mem_resp_valid && (count_q != '0);

  always_comb begin
    bus.mem_req_valid = resetN && found && not_full;
    bus.mem_req_we    = found ? bus.req_we[winner] : 1'b0;
    bus.mem_req_addr  = found ? bus.req_addr[winner*ADDR_W +: ADDR_W] : '0;
    bus.mem_req_wdata = found ? bus.req_wdata[winner*DATA_W +: DATA_W] : '0;
    bus.req_ready     = accept ? (N'(1) << winner) : '0;
    bus.resp_valid    = pop ? (N'(1) << owner_q[rd_ptr_q]) : '0;
    bus.resp_data     = bus.mem_resp_data;
    bus.outstanding   = count_q;
    bus.spurious_err  = spurious_q;
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    owner_d    = owner_q;
    spurious_d = resetN && bus.mem_resp_valid && (count_q == '0);
    if (accept) begin
      owner_d[wr_ptr_q] = winner;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
      if (PRIO_MODE == 0)
        rr_ptr_d = (winner == IDX_W'(N - 1)) ? '0 : winner + IDX_W'(1);
    end
    if (pop)
      rd_ptr_d = ptr_inc(rd_ptr_q);
    if (accept && !pop)
      count_d = count_q + CNT_W'(1);
    else if (!accept && pop)
      count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rr_ptr_q   <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      spurious_q <= 1'b0;
      for (int unsigned i = 0; i < MAX_OUT; i++) owner_q[i] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      spurious_q <= spurious_d;
      owner_q    <= owner_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter_mo.sv
// Directed bench for mem_arbiter_mo: a round-robin instance (a) and a fixed-priority instance (b).
module tb_mem_arbiter_mo;
  logic clk = 1'b0;
  logic resetN;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total    = 0;

  always #5 clk = ~clk;

  mem_arbiter_mo_if #(.N(3), .ADDR_W(16), .DATA_W(8), .MAX_OUT(4)) a ();
  mem_arbiter_mo_if #(.N(3), .ADDR_W(16), .DATA_W(8), .MAX_OUT(4)) b ();

  mem_arbiter_mo #(.N(3), .ADDR_W(16), .DATA_W(8), .MAX_OUT(4), .PRIO_MODE(0)) u_rr (
    .clk(clk), .resetN(resetN), .bus(a));
  mem_arbiter_mo #(.N(3), .ADDR_W(16), .DATA_W(8), .MAX_OUT(4), .PRIO_MODE(1)) u_fp (
    .clk(clk), .resetN(resetN), .bus(b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetN = 1'b0;
    a.req_valid = '0; a.req_we = '0; a.req_addr = '0; a.req_wdata = '0;
    a.mem_req_ready = 1'b0; a.mem_resp_valid = 1'b0; a.mem_resp_data = '0;
    b.req_valid = '0; b.req_we = '0; b.req_addr = '0; b.req_wdata = '0;
    b.mem_req_ready = 1'b0; b.mem_resp_valid = 1'b0; b.mem_resp_data = '0;

    // reset holds outputs quiet even with activity on the inputs
    a.req_valid = 3'b111; a.mem_req_ready = 1'b1; a.mem_resp_valid = 1'b1;
    repeat (2) cyc();
    #1;
    chk("rst_outstanding", a.outstanding, 0);
    chk("rst_req_ready", a.req_ready, 0);
    chk("rst_mem_req_valid", a.mem_req_valid, 0);
    chk("rst_resp_valid", a.resp_valid, 0);
    chk("rst_spurious", a.spurious_err, 0);
    a.req_valid = '0; a.mem_resp_valid = 1'b0;
    a.req_addr  = {16'h1002, 16'h1001, 16'h1000};
    a.req_wdata = {8'h12, 8'h11, 8'h10};
    a.req_we    = 3'b010;
    b.req_addr  = {16'h2002, 16'h2001, 16'h2000};
    resetN = 1'b1;
    cyc();

    #1;
    chk("idle_mem_req_valid", a.mem_req_valid, 0);
    chk("idle_addr", a.mem_req_addr, 0);
    chk("idle_we", a.mem_req_we, 0);
    chk("idle_wdata", a.mem_req_wdata, 0);
    cyc();

    // request presented but memory not ready: no acceptance
    a.req_valid = 3'b001; a.mem_req_ready = 1'b0;
    #1;
    chk("nrdy_mem_req_valid", a.mem_req_valid, 1);
    chk("nrdy_req_ready", a.req_ready, 0);
    cyc();
    chk("nrdy_outstanding", a.outstanding, 0);
    a.mem_req_ready = 1'b1;

    // round-robin fairness, responses overlapping acceptance from the 2nd cycle
    for (int c = 0; c < 6; c++) begin
      a.req_valid = 3'b111;
      a.mem_resp_valid = (c > 0);
      a.mem_resp_data = 8'h50 + 8'(c);
      #1;
      chk("rr_grant", a.req_ready, 32'd1 << (c % 3));
      chk("rr_addr", a.mem_req_addr, 32'h1000 + 32'(c % 3));
      chk("rr_wdata", a.mem_req_wdata, 32'h10 + 32'(c % 3));
      chk("rr_we", a.mem_req_we, 32'((c % 3) == 1));
      if (c > 0) begin
        chk("rr_resp_valid", a.resp_valid, 32'd1 << ((c - 1) % 3));
        chk("rr_resp_data", a.resp_data, 32'h50 + 32'(c));
      end
      cyc();
      chk("rr_outstanding", a.outstanding, 1);
    end
    a.req_valid = '0; a.mem_resp_data = 8'h5F;
    #1;
    chk("rr_last_resp", a.resp_valid, 3'b100);
    cyc();
    a.mem_resp_valid = 1'b0;
    chk("rr_drained", a.outstanding, 0);

    // spurious response
    a.mem_resp_valid = 1'b1;
    #1;
    chk("spur_resp_valid", a.resp_valid, 0);
    chk("spur_not_yet", a.spurious_err, 0);
    cyc();
    a.mem_resp_valid = 1'b0;
    chk("spur_pulse", a.spurious_err, 1);
    chk("spur_outstanding", a.outstanding, 0);
    cyc();
    chk("spur_once", a.spurious_err, 0);

    // backpressure: five requests, four slots
    a.req_valid = 3'b010;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_accept", a.req_ready, 3'b010);
      cyc();
    end
    chk("bp_full_count", a.outstanding, 4);
    #1;
    chk("bp_full_ready", a.req_ready, 0);
    chk("bp_full_mrv", a.mem_req_valid, 0);
    cyc();
    chk("bp_hold_ready", a.req_ready, 0);
    a.mem_resp_valid = 1'b1; a.mem_resp_data = 8'h77;
    #1;
    chk("bp_pop_no_push", a.req_ready, 0);
    chk("bp_pop_route", a.resp_valid, 3'b010);
    chk("bp_pop_data", a.resp_data, 8'h77);
    cyc();
    a.mem_resp_valid = 1'b0;
    chk("bp_after_pop", a.outstanding, 3);
    #1;
    chk("bp_fifth_accept", a.req_ready, 3'b010);
    cyc();
    chk("bp_refull", a.outstanding, 4);
    a.req_valid = '0; a.mem_resp_valid = 1'b1;
    repeat (4) cyc();
    a.mem_resp_valid = 1'b0;
    chk("bp_drained", a.outstanding, 0);

    // ordering: accept 2,0,1 then return A1,B2,C3
    a.req_valid = 3'b100; #1; chk("ord_acc2", a.req_ready, 3'b100); cyc();
    a.req_valid = 3'b001; #1; chk("ord_acc0", a.req_ready, 3'b001); cyc();
    a.req_valid = 3'b010; #1; chk("ord_acc1", a.req_ready, 3'b010); cyc();
    a.req_valid = '0;
    chk("ord_count", a.outstanding, 3);
    a.mem_resp_valid = 1'b1;
    a.mem_resp_data = 8'hA1; #1;
    chk("ord_r1_port", a.resp_valid, 3'b100); chk("ord_r1_data", a.resp_data, 8'hA1); cyc();
    a.mem_resp_data = 8'hB2; #1;
    chk("ord_r2_port", a.resp_valid, 3'b001); chk("ord_r2_data", a.resp_data, 8'hB2); cyc();
    a.mem_resp_data = 8'hC3; #1;
    chk("ord_r3_port", a.resp_valid, 3'b010); chk("ord_r3_data", a.resp_data, 8'hC3); cyc();
    a.mem_resp_valid = 1'b0;
    chk("ord_drained", a.outstanding, 0);

    // simultaneous push/pop at outstanding=2 (pointer is 2 here)
    a.req_valid = 3'b001; #1; chk("pp_acc0", a.req_ready, 3'b001); cyc();
    a.req_valid = 3'b100; #1; chk("pp_acc2", a.req_ready, 3'b100); cyc();
    chk("pp_count2", a.outstanding, 2);
    a.req_valid = 3'b010; a.mem_resp_valid = 1'b1; a.mem_resp_data = 8'h11;
    #1;
    chk("pp_push", a.req_ready, 3'b010);
    chk("pp_pop_oldest", a.resp_valid, 3'b001);
    cyc();
    a.req_valid = '0;
    chk("pp_count_hold", a.outstanding, 2);
    a.mem_resp_data = 8'h22; #1; chk("pp_next_owner", a.resp_valid, 3'b100); cyc();
    a.mem_resp_data = 8'h33; #1; chk("pp_last_owner", a.resp_valid, 3'b010); cyc();
    a.mem_resp_valid = 1'b0;
    chk("pp_drained", a.outstanding, 0);

    // reset with three outstanding (pointer left at 1 beforehand)
    a.req_valid = 3'b001;
    repeat (3) cyc();
    a.req_valid = '0;
    chk("mrst_pre_count", a.outstanding, 3);
    resetN = 1'b0;
    #1;
    chk("mrst_count", a.outstanding, 0);
    chk("mrst_mrv", a.mem_req_valid, 0);
    cyc();
    resetN = 1'b1;
    cyc();
    a.req_valid = 3'b111;
    #1;
    chk("mrst_ptr_zero", a.req_ready, 3'b001);
    cyc();
    a.req_valid = '0;
    a.mem_resp_valid = 1'b1; cyc();
    a.mem_resp_valid = 1'b1;
    #1;
    chk("mrst_late_resp", a.resp_valid, 0);
    cyc();
    a.mem_resp_valid = 1'b0;
    chk("mrst_spurious", a.spurious_err, 1);

    // fixed priority instance
    b.mem_req_ready = 1'b1; b.req_valid = 3'b111;
    #1;
    chk("fp_lowest", b.req_ready, 3'b001);
    cyc();
    b.req_valid = 3'b110; b.mem_resp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fp_port1", b.req_ready, 3'b010);
      chk("fp_addr", b.mem_req_addr, 16'h2001);
      cyc();
    end
    chk("fp_count", b.outstanding, 1);
    b.req_valid = '0;
    cyc();
    b.mem_resp_valid = 1'b0;
    chk("fp_drained", b.outstanding, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
